// File: rtl/cn_state_loader.sv
// cn_state_loader: input-side driver for the CryptoNight core.
//
// Packs 25 host words (64 bits each) into a 1600-bit Keccak state. Each state is then issued
// to the core as one job, tagged with an incrementing 8-bit nonce. The loader counts jobs
// issued but not yet returned and stops issuing while MAX_INFLIGHT jobs are outstanding.
//
// Optional feature macro: CN_LOADER_NONCE_CHECK_EN
//   Defined: returned nonces must come back in issue order. Any out-of-order return, or a
//   return with nothing outstanding, sets err_nonce.
//   Undefined: err_nonce is tied to 0 and done_nonce is ignored.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready   host word stream (s_last marks word 24)
//   m_state/m_nonce/m_valid/m_ready job handshake to the core
//   done_in/done_nonce              job completion pulse and nonce from the core
//   err_clr           clears the sticky error flags
//   inflight          jobs issued and not yet returned
//   err_framing       sticky: s_last was misplaced within a state
//   err_nonce         sticky: a job came back out of order
module cn_state_loader #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [63:0]      s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [1599:0]    m_state,
  output logic [7:0]       m_nonce,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             done_in,
  input  logic [7:0]       done_nonce,
  input  logic             err_clr,
  output logic [CNT_W-1:0] inflight,
  output logic             err_framing,
  output logic             err_nonce
);

  typedef enum logic {StFill, StIssue} state_e;

  state_e             state_q, state_d;
  logic [4:0]         idx_q, idx_d;
  logic               s_ready_q;
  logic [1599:0]      state_buf_q;
  logic [7:0]         nonce_q, nonce_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               err_framing_q, err_framing_d;
  logic               word_acc, word_we, framing_hit, xfer, done_eff, full;

  // Gating uses the registered count, so a same-cycle done_in cannot unblock issue.
  assign full     = (inflight_q == CNT_W'(MAX_INFLIGHT));
  assign m_valid  = (state_q == StIssue) && !full;
  assign xfer     = m_valid && m_ready;
  assign word_acc = s_valid && s_ready_q && (state_q == StFill);
  assign done_eff = done_in && (inflight_q != '0);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nonce_d     = nonce_q;
    word_we     = 1'b0;
    framing_hit = 1'b0;
    unique case (state_q)
      StFill: begin
        if (word_acc) begin
          if (s_last && (idx_q == 5'd24)) begin
            word_we = 1'b1;
            idx_d   = '0;
            state_d = StIssue;
          end else if (s_last || (idx_q == 5'd24)) begin
            // Misframed word is dropped; restart the state from word 0.
            framing_hit = 1'b1;
            idx_d       = '0;
          end else begin
            word_we = 1'b1;
            idx_d   = idx_q + 5'd1;
          end
        end
      end
      StIssue: begin
        if (xfer) begin
          state_d = StFill;
          nonce_d = nonce_q + 8'd1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({xfer, done_eff})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // A new error takes priority over a same-cycle clear.
  assign err_framing_d = (err_framing_q && !err_clr) || framing_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StFill;
      idx_q         <= '0;
      s_ready_q     <= 1'b0;
      state_buf_q   <= '0;
      nonce_q       <= '0;
      inflight_q    <= '0;
      err_framing_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      s_ready_q     <= (state_d == StFill);
      nonce_q       <= nonce_d;
      inflight_q    <= inflight_d;
      err_framing_q <= err_framing_d;
      if (word_we) state_buf_q[{idx_q, 6'd0} +: 64] <= s_data;
    end
  end

`ifdef CN_LOADER_NONCE_CHECK_EN
  logic [7:0] exp_nonce;
  logic       nonce_hit;
  logic       err_nonce_q;

  // Oldest outstanding job, given in-order return.
  assign exp_nonce = nonce_q - 8'(inflight_q);
  assign nonce_hit = done_in && ((inflight_q == '0) || (done_nonce != exp_nonce));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_nonce_q <= 1'b0;
    else       err_nonce_q <= (err_nonce_q && !err_clr) || nonce_hit;
  end

  assign err_nonce = err_nonce_q;
`else
  logic unused_done_nonce;
  assign unused_done_nonce = ^done_nonce;
  assign err_nonce         = 1'b0;
`endif

  assign s_ready     = s_ready_q;
  assign m_state     = state_buf_q;
  assign m_nonce     = nonce_q;
  assign inflight    = inflight_q;
  assign err_framing = err_framing_q;

endmodule
